// File: rtl/post_box_spi_master.sv
// SPI mode-0 initiator for the post-box link. Each frame carries 16 bits: two
// flow-control flags and one data byte in each direction, with TX and RX holding registers.
module post_box_spi_master #(
  parameter int HALF_PERIOD   = 12,
  parameter int CS_SETUP      = 24,
  parameter int CS_GAP        = 24,
  parameter int POLL_INTERVAL = 480
) (
  input  logic       fpga_clock_48mhz,
  input  logic       reset,
  output logic       spi_cs,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic       tx_sent,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_done
);

  // state | meaning
  // GAP   | CS held high between frames
  // IDLE  | waiting for a held byte or the poll timer
  // SETUP | CS low, before the first SCK rise
  // HIGH  | SCK high phase, MISO bit just captured
  // LOW   | SCK low phase, next MOSI bit presented
  // HOLD  | after the last SCK fall, before CS rises and the frame commits
  localparam logic [2:0] S_GAP   = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_LOW   = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  localparam int MAX_A = (HALF_PERIOD > CS_SETUP) ? HALF_PERIOD : CS_SETUP;
  localparam int MAX_B = (CS_GAP > POLL_INTERVAL) ? CS_GAP : POLL_INTERVAL;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW-1:0] T_HALF  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] T_SETUP = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0] T_GAP   = TW'(CS_GAP - 1);
  localparam logic [TW-1:0] T_POLL  = TW'(POLL_INTERVAL - 1);

  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_edge;
  logic [14:0]   r_tx_shift;
  logic [7:0]    r_rx_byte;
  logic          r_rem_has_byte;
  logic          r_rem_has_space;
  logic          r_miso_s1;
  logic          r_miso_s2;
  logic          r_tx_full;
  logic [7:0]    r_tx_byte;
  logic          r_rx_valid;
  logic [7:0]    r_rx_data;
  logic          r_lat_full;
  logic          r_lat_space;
  logic          r_cs;
  logic          r_sck;
  logic          r_mosi;
  logic          r_tx_sent;
  logic          r_frame_done;

  logic          w_tc;
  logic [15:0]   w_word;

  assign w_tc   = (r_timer == '0);
  // The data byte is sent only while it is held; otherwise those bits are zero.
  assign w_word = {r_tx_full, ~r_rx_valid, 6'b0, (r_tx_full ? r_tx_byte : 8'h00)};

  always_ff @(posedge fpga_clock_48mhz) begin
    if (reset) begin
      r_state         <= S_GAP;
      r_timer         <= T_GAP;
      r_edge          <= 4'd0;
      r_tx_shift      <= '0;
      r_rx_byte       <= 8'h00;
      r_rem_has_byte  <= 1'b0;
      r_rem_has_space <= 1'b0;
      r_miso_s1       <= 1'b0;
      r_miso_s2       <= 1'b0;
      r_tx_full       <= 1'b0;
      r_tx_byte       <= 8'h00;
      r_rx_valid      <= 1'b0;
      r_rx_data       <= 8'h00;
      r_lat_full      <= 1'b0;
      r_lat_space     <= 1'b0;
      r_cs            <= 1'b1;
      r_sck           <= 1'b0;
      r_mosi          <= 1'b0;
      r_tx_sent       <= 1'b0;
      r_frame_done    <= 1'b0;
    end else begin
      r_miso_s1    <= spi_miso;
      r_miso_s2    <= r_miso_s1;
      r_tx_sent    <= 1'b0;
      r_frame_done <= 1'b0;

      if (tx_load && !r_tx_full) begin
        r_tx_full <= 1'b1;
        r_tx_byte <= tx_data;
      end
      if (rx_ack && r_rx_valid) r_rx_valid <= 1'b0;

      case (r_state)
        S_GAP: begin
          if (w_tc) begin
            r_state <= S_IDLE;
            r_timer <= T_POLL;
          end else r_timer <= r_timer - 1'b1;
        end
        S_IDLE: begin
          if (r_tx_full || w_tc) begin
            r_cs        <= 1'b0;
            r_mosi      <= w_word[15];
            r_tx_shift  <= w_word[14:0];
            r_lat_full  <= r_tx_full;
            r_lat_space <= ~r_rx_valid;
            r_edge      <= 4'd0;
            r_timer     <= T_SETUP;
            r_state     <= S_SETUP;
          end else r_timer <= r_timer - 1'b1;
        end
        S_SETUP, S_LOW: begin
          if (w_tc) begin
            r_sck     <= 1'b1;
            r_rx_byte <= {r_rx_byte[6:0], r_miso_s2};
            if (r_edge == 4'd0) r_rem_has_byte <= r_miso_s2;
            if (r_edge == 4'd1) r_rem_has_space <= r_miso_s2;
            r_timer   <= T_HALF;
            r_state   <= S_HIGH;
          end else r_timer <= r_timer - 1'b1;
        end
        S_HIGH: begin
          if (w_tc) begin
            r_sck   <= 1'b0;
            r_timer <= T_HALF;
            if (r_edge == 4'd15) begin
              r_state <= S_HOLD;
            end else begin
              r_mosi     <= r_tx_shift[14];
              r_tx_shift <= {r_tx_shift[13:0], 1'b0};
              r_edge     <= r_edge + 4'd1;
              r_state    <= S_LOW;
            end
          end else r_timer <= r_timer - 1'b1;
        end
        S_HOLD: begin
          if (w_tc) begin
            r_cs         <= 1'b1;
            r_frame_done <= 1'b1;
            if (r_lat_full && r_rem_has_space) begin
              r_tx_full <= 1'b0;
              r_tx_sent <= 1'b1;
            end
            // Flags were latched at CS fall, so a mid-frame rx_ack cannot open space here.
            if (r_lat_space && r_rem_has_byte) begin
              r_rx_data  <= r_rx_byte;
              r_rx_valid <= 1'b1;
            end
            r_timer <= T_GAP;
            r_state <= S_GAP;
          end else r_timer <= r_timer - 1'b1;
        end
        default: begin
          r_state <= S_GAP;
          r_timer <= T_GAP;
        end
      endcase
    end
  end

  assign spi_cs     = r_cs;
  assign spi_sck    = r_sck;
  assign spi_mosi   = r_mosi;
  assign tx_empty   = ~r_tx_full;
  assign tx_sent    = r_tx_sent;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_post_box_spi_master.sv
// Bench for post_box_spi_master: directed frame table, randomized traffic checked by a
// frame-level reference model with a responder model, and a mid-frame reset sequence.
module tb_post_box_spi_master;

  localparam int HP    = 8;
  localparam int SETUP = 8;
  localparam int GAP   = 10;
  localparam int POLL  = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_cs, spi_sck, spi_mosi;
  logic       spi_miso = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_empty, tx_sent;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       frame_done;

  post_box_spi_master #(
    .HALF_PERIOD(HP), .CS_SETUP(SETUP), .CS_GAP(GAP), .POLL_INTERVAL(POLL)
  ) dut (
    .fpga_clock_48mhz(clk), .reset(reset),
    .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty), .tx_sent(tx_sent),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model state (holding registers and the frame in flight).
  logic        m_full = 1'b0, m_valid = 1'b0;
  logic [7:0]  m_byte = 8'h00, m_data = 8'h00;
  logic        lat_full = 1'b0, lat_space = 1'b0;
  logic [15:0] exp_word = 16'h0, rsp = 16'h0, rsp_next = 16'h0;
  logic [15:0] mosi_acc = 16'h0, last_mosi = 16'h0;
  logic        prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
  int          n_edges = 0, ridx = -1, high_cnt = 0, low_cnt = 0;

  always @(posedge clk) begin
    logic cs_fell, cs_rose, sck_rose, sck_fell, pre_full, pre_valid, exp_sent;
    #1;
    if (reset) begin
      check("reset_pins", {29'd0, spi_cs, spi_sck, spi_mosi}, 32'h4);
      check("reset_flags", {20'd0, tx_empty, tx_sent, rx_valid, frame_done, rx_data}, 32'h800);
      m_full = 1'b0; m_valid = 1'b0; m_data = 8'h00;
      prev_cs = 1'b1; prev_sck = 1'b0; prev_mosi = 1'b0;
      high_cnt = 1; ridx = -1; spi_miso = 1'b0;
    end else begin
      cs_fell  = prev_cs && !spi_cs;
      cs_rose  = !prev_cs && spi_cs;
      sck_rose = !prev_sck && spi_sck;
      sck_fell = prev_sck && !spi_sck;
      pre_full = m_full;
      pre_valid = m_valid;
      exp_sent = 1'b0;
      if (spi_mosi !== prev_mosi) check("mosi_change_point", {31'd0, cs_fell | sck_fell}, 32'd1);
      if (cs_fell) begin
        // A poll waits the full gap plus poll interval; a held byte starts no later than that.
        if (pre_full)
          check("cs_high_forced", {31'd0, (high_cnt > GAP) && (high_cnt <= GAP + POLL)}, 32'd1);
        else
          check("cs_high_poll", high_cnt, GAP + POLL);
        lat_full  = pre_full;
        lat_space = !pre_valid;
        exp_word  = {pre_full, !pre_valid, 6'b0, (pre_full ? m_byte : 8'h00)};
        rsp       = rsp_next;
        mosi_acc  = 16'h0;
        n_edges   = 0;
        low_cnt   = 0;
        spi_miso  = rsp[15];
        ridx      = 14;
      end
      if (sck_rose) begin
        mosi_acc = {mosi_acc[14:0], spi_mosi};
        n_edges++;
      end
      if (sck_fell && ridx >= 0) begin
        spi_miso = rsp[ridx];
        ridx--;
      end
      if (tx_load && !pre_full) begin
        m_full = 1'b1;
        m_byte = tx_data;
      end
      if (rx_ack && pre_valid) m_valid = 1'b0;
      if (cs_rose) begin
        check("frame_mosi", {16'd0, mosi_acc}, {16'd0, exp_word});
        check("sck_edges", n_edges, 16);
        check("cs_low_len", low_cnt, SETUP + 32 * HP);
        last_mosi = mosi_acc;
        if (lat_full && rsp[14]) begin
          m_full = 1'b0;
          exp_sent = 1'b1;
        end
        if (lat_space && rsp[15]) begin
          m_valid = 1'b1;
          m_data  = rsp[7:0];
        end
        high_cnt = 0;
        ridx = -1;
      end
      check("status", {20'd0, tx_empty, tx_sent, rx_valid, frame_done, rx_data},
            {20'd0, !m_full, exp_sent, m_valid, cs_rose, m_data});
      if (spi_cs) high_cnt++;
      else low_cnt++;
      prev_cs = spi_cs;
      prev_sck = spi_sck;
      prev_mosi = spi_mosi;
    end
  end

  typedef struct {
    logic        load;
    logic [7:0]  data;
    logic        ack;
    logic [15:0] rsp;
    logic [15:0] mosi;
    logic        sent;
    logic        empty;
    logic        rxv;
    logic [7:0]  rxd;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_frame(output logic got);
    got = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #2;
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("frame_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic got;
    int   cnt;
    vecs[0] = '{1'b0, 8'h00, 1'b0, 16'h0000, 16'h4000, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'hA5, 1'b0, 16'h4000, 16'hC0A5, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 8'h3C, 1'b0, 16'h0000, 16'hC03C, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 16'h0000, 16'hC03C, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 16'h4000, 16'hC03C, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 16'hC05A, 16'h4000, 1'b0, 1'b1, 1'b1, 8'h5A};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 16'hC077, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h5A};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 16'h8011, 16'h4000, 1'b0, 1'b1, 1'b1, 8'h11};
    vecs[8] = '{1'b1, 8'h81, 1'b1, 16'hC0EE, 16'hC081, 1'b1, 1'b1, 1'b1, 8'hEE};
    vecs[9] = '{1'b1, 8'h12, 1'b0, 16'hC033, 16'h8012, 1'b1, 1'b1, 1'b1, 8'hEE};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rsp_next = vecs[i].rsp;
      tx_load  = vecs[i].load;
      tx_data  = vecs[i].data;
      rx_ack   = vecs[i].ack;
      @(negedge clk);
      tx_load = 1'b0;
      rx_ack  = 1'b0;
      wait_frame(got);
      check($sformatf("vec%0d_mosi", i), {16'd0, last_mosi}, {16'd0, vecs[i].mosi});
      check($sformatf("vec%0d_sent", i), {31'd0, tx_sent}, {31'd0, vecs[i].sent});
      check($sformatf("vec%0d_empty", i), {31'd0, tx_empty}, {31'd0, vecs[i].empty});
      check($sformatf("vec%0d_rxv", i), {31'd0, rx_valid}, {31'd0, vecs[i].rxv});
      check($sformatf("vec%0d_rxd", i), {24'd0, rx_data}, {24'd0, vecs[i].rxd});
    end

    // Random traffic, including loads and acks mid-frame and in commit cycles.
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      tx_load  = ($urandom_range(0, 39) == 0);
      tx_data  = 8'($urandom);
      rx_ack   = ($urandom_range(0, 29) == 0);
      rsp_next = 16'($urandom);
    end
    @(negedge clk);
    tx_load = 1'b0;
    rx_ack  = 1'b0;

    // Reset at SCK edge 5 while a byte is held.
    wait_frame(got);
    @(negedge clk);
    rsp_next = 16'h4000;
    tx_load  = tx_empty;
    tx_data  = 8'h99;
    @(negedge clk);
    tx_load = 1'b0;
    check("held_before_reset", {31'd0, tx_empty}, 32'd0);
    got = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #2;
      if (!spi_cs && spi_sck && n_edges == 6) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("edge5_timeout", 32'd0, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("midreset_cs_sck", {30'd0, spi_cs, spi_sck}, 32'h2);
    check("midreset_flags", {29'd0, tx_empty, tx_sent, frame_done}, 32'h4);
    @(negedge clk);
    reset = 1'b0;
    cnt = 1;
    got = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #2;
      if (!spi_cs) begin
        got = 1'b1;
        break;
      end
      cnt++;
    end
    check("post_reset_gap", {31'd0, got && (cnt >= GAP)}, 32'd1);
    wait_frame(got);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
